// File: rtl/instr_pkg.sv
// Shared encoder constants: op selects, opcodes, funct codes and the FSM state type.
// The PAD state exists only when BRANCH_NOP_PAD_EN is defined.
package instr_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_ADDI  = 4'd6;
    localparam logic [3:0] OP_LOAD  = 4'd7;
    localparam logic [3:0] OP_STORE = 4'd8;
    localparam logic [3:0] OP_BEQ   = 4'd9;
    localparam logic [3:0] OP_JMP   = 4'd10;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_JMP   = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LOAD  = 6'h20;
    localparam logic [5:0] OPC_STORE = 6'h30;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

`ifdef BRANCH_NOP_PAD_EN
    typedef enum logic [1:0] {IDLE, HOLD, PAD} encState_t;
`else
    typedef enum logic [0:0] {IDLE, HOLD} encState_t;
`endif

    function automatic logic isBranchOp(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer: op select plus register/immediate/target fields -> 32-bit word.
// Zero latency, no backpressure; codes outside the op table raise illegal and yield a zero word.
module instr_field_pack
    import instr_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op)
            OP_NOP:   word = '0;
            OP_ADD:   word = {OPC_RTYPE, rs, rt, rd, 5'h00, FN_ADD};
            OP_SUB:   word = {OPC_RTYPE, rs, rt, rd, 5'h00, FN_SUB};
            OP_AND:   word = {OPC_RTYPE, rs, rt, rd, 5'h00, FN_AND};
            OP_OR:    word = {OPC_RTYPE, rs, rt, rd, 5'h00, FN_OR};
            OP_SLT:   word = {OPC_RTYPE, rs, rt, rd, 5'h00, FN_SLT};
            OP_ADDI:  word = {OPC_ADDI, rs, rt, imm};
            OP_LOAD:  word = {OPC_LOAD, rs, rt, imm};
            OP_STORE: word = {OPC_STORE, rs, rt, imm};
            OP_BEQ:   word = {OPC_BEQ, rs, rt, imm};
            OP_JMP:   word = {OPC_JMP, target};
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes field sets into words written sequentially to instruction memory; one-cycle accept-to-write latency.
// Holds the word while mem_ready is low; stops at the top address. BRANCH_NOP_PAD_EN adds NOP padding after BEQ/JMP.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int PAD_COUNT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              illegal,
    output logic              full,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    logic [31:0] packWord;
    logic        packIllegal;
    encState_t   state;
    logic        accept;
    logic        complete;
    logic        lastAddr;
    logic        canChain;

    instr_field_pack uPack (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .word    (packWord),
        .illegal (packIllegal)
    );

`ifdef BRANCH_NOP_PAD_EN
    localparam int PAD_W = (PAD_COUNT > 1) ? $clog2(PAD_COUNT + 1) : 1;
    localparam logic [PAD_W-1:0] PAD_ONE = 1;

    logic             holdBranch;
    logic             nextBranch;
    logic [PAD_W-1:0] padLeft;

    assign nextBranch = isBranchOp(in_op) && (PAD_COUNT > 0);
    // A pending branch word is followed by padding, so nothing may chain behind it.
    assign canChain   = (state == HOLD) && !holdBranch;
`else
    assign canChain   = (state == HOLD);
`endif

    assign lastAddr = (mem_addr == '1);
    assign complete = mem_we && mem_ready;
    // Refuse chaining onto the final write: it sets full and nothing may follow it.
    assign in_ready = !full && ((state == IDLE) || (canChain && mem_ready && !lastAddr));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            mem_addr   <= ADDR_W'(BASE_ADDR);
            word_count <= '0;
            illegal    <= 1'b0;
            full       <= 1'b0;
`ifdef BRANCH_NOP_PAD_EN
            holdBranch <= 1'b0;
            padLeft    <= '0;
`endif
        end else begin
            illegal <= accept && packIllegal;

            if (complete) begin
                word_count <= word_count + CNT_ONE;
                if (lastAddr) begin
                    full <= 1'b1;
                end else begin
                    mem_addr <= mem_addr + ADDR_ONE;
                end
            end

            case (state)
                IDLE: begin
                    if (accept && !packIllegal) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= packWord;
                        state     <= HOLD;
`ifdef BRANCH_NOP_PAD_EN
                        holdBranch <= nextBranch;
`endif
                    end
                end
                HOLD: begin
                    if (complete) begin
                        if (lastAddr) begin
                            mem_we <= 1'b0;
                            state  <= IDLE;
                        end
`ifdef BRANCH_NOP_PAD_EN
                        else if (holdBranch) begin
                            mem_wdata <= '0;
                            padLeft   <= PAD_W'(PAD_COUNT);
                            state     <= PAD;
                        end
`endif
                        else if (accept && !packIllegal) begin
                            mem_wdata <= packWord;
`ifdef BRANCH_NOP_PAD_EN
                            holdBranch <= nextBranch;
`endif
                        end else begin
                            mem_we <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
`ifdef BRANCH_NOP_PAD_EN
                PAD: begin
                    if (complete) begin
                        // Running out of memory drops whatever padding is still owed.
                        if (lastAddr || (padLeft == PAD_ONE)) begin
                            mem_we     <= 1'b0;
                            holdBranch <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            padLeft <= padLeft - PAD_ONE;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: encoding table, hand sequences for stall/back-to-back/full/padding, random run against a queue model.
module tb_instr_encoder;

    localparam int AW   = 3;
    localparam int CAP  = 1 << AW;
    localparam int PADN = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid, in_ready, mem_we, mem_ready, illegal, full;
    logic [3:0]    in_op;
    logic [4:0]    in_rs, in_rt, in_rd;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   word_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0), .PAD_COUNT(PADN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .illegal(illegal), .full(full), .word_count(word_count)
    );

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] word;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        bit          pad;
    } exp_t;

    vec_t vecs[14];
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bit 32 flags an illegal op; the word is built from field weights rather than concatenation.
    function automatic logic [32:0] refEncode(input int op, input longint rs, input longint rt,
                                              input longint rd, input longint imm, input longint tgt);
        longint functs[5] = '{32, 34, 36, 37, 42};
        longint iopc[4]   = '{8, 32, 48, 4};
        if (op == 0) return 33'd0;
        if (op >= 1 && op <= 5) return 33'(rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + functs[op - 1]);
        if (op >= 6 && op <= 9) return 33'(iopc[op - 6] * (64'd1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm);
        if (op == 10) return 33'(2 * (64'd1 << 26) + tgt);
        return 33'h1_0000_0000;
    endfunction

    task automatic idleInputs();
        in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_imm = '0; in_target = '0; mem_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 reset = 1'b1;
        idleInputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tgt;
    endtask

    initial begin
        int writes;
        int accepted;
        int completed;
        int len;
        bit expIll;
        bit expReady;
        logic [32:0] r;

        idleInputs();
        vecs[0]  = '{4'd1,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0000000, 32'h00221820, 1'b0};
        vecs[1]  = '{4'd2,  5'd31, 5'd0,  5'd31, 16'hABCD, 26'h3FFFFFF, 32'h03E0F822, 1'b0};
        vecs[2]  = '{4'd3,  5'd5,  5'd6,  5'd7,  16'h0000, 26'h0000000, 32'h00A63824, 1'b0};
        vecs[3]  = '{4'd4,  5'd0,  5'd31, 5'd1,  16'h0000, 26'h0000000, 32'h001F0825, 1'b0};
        vecs[4]  = '{4'd5,  5'd2,  5'd3,  5'd4,  16'h1234, 26'h0000155, 32'h0043202A, 1'b0};
        vecs[5]  = '{4'd6,  5'd4,  5'd5,  5'd31, 16'hFFFF, 26'h2AAAAAA, 32'h2085FFFF, 1'b0};
        vecs[6]  = '{4'd7,  5'd0,  5'd1,  5'd0,  16'h0004, 26'h0000000, 32'h80010004, 1'b0};
        vecs[7]  = '{4'd8,  5'd3,  5'd9,  5'd17, 16'h1234, 26'h0000000, 32'hC0691234, 1'b0};
        vecs[8]  = '{4'd9,  5'd1,  5'd1,  5'd0,  16'hFFFE, 26'h0000000, 32'h1021FFFE, 1'b0};
        vecs[9]  = '{4'd10, 5'd7,  5'd7,  5'd7,  16'hFFFF, 26'h0000010, 32'h08000010, 1'b0};
        vecs[10] = '{4'd10, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0BFFFFFF, 1'b0};
        vecs[11] = '{4'd0,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h00000000, 1'b0};
        vecs[12] = '{4'd11, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0000000, 32'h00000000, 1'b1};
        vecs[13] = '{4'd15, 5'd9,  5'd9,  5'd9,  16'h5555, 26'h1555555, 32'h00000000, 1'b1};

        repeat (2) tick();
        reset = 1'b0;

        // Reset state
        doReset();
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        // Encoding table: one op from IDLE, checked the cycle after acceptance
        for (int i = 0; i < 14; i++) begin
            doReset();
            drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].tgt);
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d_we", i), 32'(mem_we), 32'(!vecs[i].ill));
            check($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
            check($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'd0);
            if (!vecs[i].ill) check($sformatf("vec%0d_word", i), mem_wdata, vecs[i].word);
            tick();
            check($sformatf("vec%0d_pulse_end", i), 32'(illegal), 32'd0);
            check($sformatf("vec%0d_count", i), 32'(word_count), 32'(!vecs[i].ill));
        end

        // Back-to-back ADDI then LOAD
        doReset();
        drive(4'd6, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'd0);
        tick();
        check("b2b_w0", mem_wdata, 32'h2085FFFF);
        check("b2b_a0", 32'(mem_addr), 32'd0);
        drive(4'd7, 5'd0, 5'd1, 5'd0, 16'h0004, 26'd0);
        #1;
        check("b2b_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("b2b_we1", 32'(mem_we), 32'd1);
        check("b2b_w1", mem_wdata, 32'h80010004);
        check("b2b_a1", 32'(mem_addr), 32'd1);
        tick();
        check("b2b_idle", 32'(mem_we), 32'd0);
        check("b2b_count", 32'(word_count), 32'd2);

        // SUB stalled for three cycles
        doReset();
        drive(4'd2, 5'd8, 5'd9, 5'd10, 16'd0, 26'd0);
        mem_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_we", 32'(mem_we), 32'd1);
            check("stall_word", mem_wdata, 32'h01095022);
            check("stall_addr", 32'(mem_addr), 32'd0);
            check("stall_ready", 32'(in_ready), 32'd0);
            if (k == 2) mem_ready = 1'b1;
            tick();
        end
        check("stall_done", 32'(mem_we), 32'd0);
        check("stall_count", 32'(word_count), 32'd1);
        tick();
        check("stall_once", 32'(word_count), 32'd1);

        // Fill memory with NOPs offered continuously
        doReset();
        drive(4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        writes = 0;
        accepted = 0;
        for (int k = 0; k < CAP + 6; k++) begin
            #1;
            if (mem_we && mem_ready) begin
                check("fill_addr", 32'(mem_addr), 32'(writes));
                writes++;
            end
            if (in_valid && in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        check("fill_writes", 32'(writes), 32'(CAP));
        check("fill_accepted", 32'(accepted), 32'(CAP));
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(word_count), 32'(CAP));
        check("fill_addr_hold", 32'(mem_addr), 32'(CAP - 1));
        check("fill_ready", 32'(in_ready), 32'd0);

`ifdef BRANCH_NOP_PAD_EN
        // JMP followed by padding while another op is kept on offer
        doReset();
        drive(4'd10, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
        tick();
        drive(4'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("pad_we", 32'(mem_we), 32'd1);
            check("pad_addr", 32'(mem_addr), 32'(k));
            check("pad_word", mem_wdata, (k == 0) ? 32'h08000010 : 32'h00000000);
            check("pad_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check("pad_ready_end", 32'(in_ready), 32'd1);
        check("pad_count", 32'(word_count), 32'd3);
        in_valid = 1'b0;
`endif

        // Random episodes against the queue model, each ending in a reset
        for (int ep = 0; ep < 40; ep++) begin
            doReset();
            q.delete();
            completed = 0;
            expIll = 1'b0;
            len = $urandom_range(5, 40);
            for (int c = 0; c < len; c++) begin
                check("rnd_illegal", 32'(illegal), 32'(expIll));
                expIll = 1'b0;
                check("rnd_we", 32'(mem_we), 32'(q.size() != 0));
                check("rnd_count", 32'(word_count), 32'(completed));
                check("rnd_full", 32'(full), 32'(completed == CAP));
                drive(($urandom % 8 == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10)),
                      5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
                in_valid = ($urandom % 4) != 0;
                mem_ready = ($urandom % 4) != 0;
                #1;
                expReady = (completed < CAP) &&
                           ((q.size() == 0) ||
                            ((q.size() == 1) && !q[0].pad && mem_ready && (completed + 1 < CAP)));
                check("rnd_ready", 32'(in_ready), 32'(expReady));
                if (mem_we && mem_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rnd_spurious_write: addr %0d with nothing pending", mem_addr);
                    end else begin
                        check("rnd_waddr", 32'(mem_addr), 32'(completed));
                        check("rnd_wdata", mem_wdata, q[0].word);
                        void'(q.pop_front());
                        completed++;
                    end
                end
                if (in_valid && in_ready) begin
                    r = refEncode(int'(in_op), longint'(in_rs), longint'(in_rt), longint'(in_rd),
                                  longint'(in_imm), longint'(in_target));
                    if (r[32]) begin
                        expIll = 1'b1;
                    end else begin
                        q.push_back('{r[31:0], 1'b0});
`ifdef BRANCH_NOP_PAD_EN
                        if (in_op == 4'd9 || in_op == 4'd10)
                            for (int k = 0; k < PADN; k++)
                                if (completed + q.size() < CAP) q.push_back('{32'd0, 1'b1});
`endif
                    end
                end
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameters SHALL be: ADDR_W, 8, instruction-memory address width; BASE_ADDR, 0, first write address; PAD_COUNT, 1, NOPs after a branch or jump (used only under REQ-024).
REQ-002 Ports SHALL be: clk  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-003 Ports SHALL be: in_valid  in  1  field set valid; in_ready  out  1  field set accepted when both are high.
REQ-004 Ports SHALL be: in_op  in  4  operation select; in_rs, in_rt, in_rd  in  5 each  register ids; in_imm  in  16  immediate; in_target  in  26  jump target.
REQ-005 Ports SHALL be: mem_we  out  1  write request; mem_addr  out  ADDR_W  word address; mem_wdata  out  32  encoded word; mem_ready  in  1  write accepted when mem_we is high.
REQ-006 Ports SHALL be: illegal  out  1  one-cycle pulse for a rejected op; full  out  1  memory exhausted; word_count  out  ADDR_W+1  number of completed writes.

Function
REQ-007 in_op codes SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 ADDI, 7 LOAD, 8 STORE, 9 BEQ, 10 JMP; codes 11-15 are illegal.
REQ-008 R-type words (ADD, SUB, AND, OR, SLT) SHALL be {6'h00, rs, rt, rd, 5'h00, funct}, with funct 0x20, 0x22, 0x24, 0x25, 0x2A respectively.
REQ-009 I-type words SHALL be {opcode, rs, rt, imm}, with opcode 0x08 ADDI, 0x20 LOAD, 0x30 STORE, 0x04 BEQ.
REQ-010 JMP SHALL encode as {6'h02, target}, and NOP SHALL encode as 32'h00000000.
REQ-011 Unused fields for an op SHALL be ignored and SHALL NOT affect the encoded word.
REQ-012 The FSM SHALL have states IDLE (no word pending), HOLD (word pending on the memory port), and PAD (macro only).
REQ-013 in_ready SHALL be 1 only in IDLE, or in HOLD while mem_ready=1, and SHALL always be 0 when full=1.
REQ-014 A legal op accepted at edge N SHALL present mem_we=1 with its word during cycle N+1 (one-cycle latency); the state becomes HOLD.
REQ-015 In HOLD with mem_ready=0, mem_we, mem_addr and mem_wdata SHALL hold stable.
REQ-016 A write SHALL complete when mem_we and mem_ready are both 1; mem_addr then increments by 1 and word_count by 1.
REQ-017 Completion and a new acceptance in the same cycle SHALL give back-to-back writes with no bubble.
REQ-018 An accepted illegal op SHALL be consumed, SHALL pulse illegal for exactly the cycle after acceptance, and SHALL produce no write and no address change.
REQ-019 full SHALL assert on completion of the write to address 2^ADDR_W-1; the address SHALL NOT wrap.
REQ-020 After full asserts, no further writes SHALL occur until reset.
REQ-021 If full asserts while PAD NOPs are outstanding, the remaining NOPs SHALL be dropped and the FSM SHALL go to IDLE.

Reset
REQ-022 On reset=1 at a clk edge, the block SHALL set: state IDLE, mem_we 0, mem_wdata 0, mem_addr BASE_ADDR, word_count 0, illegal 0, full 0, in_ready 1 the following cycle.
REQ-023 Reset mid-operation SHALL discard any pending word or PAD sequence without completing it.

Configuration
REQ-024 With BRANCH_NOP_PAD_EN defined, completion of a BEQ or JMP write SHALL enter PAD; PAD emits PAD_COUNT NOP words, each using the REQ-015/016 handshake; in_ready=0 throughout PAD; the FSM returns to IDLE after the last NOP completes.
REQ-025 Without BRANCH_NOP_PAD_EN, the PAD state and its counter SHALL be absent, and BEQ or JMP SHALL behave like any other op.

Structure
REQ-026 Shared package instr_pkg SHALL hold the in_op code constants, the opcode and funct constants, and the FSM state typedef; the decoder side SHALL reuse the same constants.
REQ-027 Field packing SHALL be one combinational sub-module, instr_field_pack (in_op plus fields -> 32-bit word plus an illegal flag); instr_encoder holds the FSM, address, count and output registers.

Verification
REQ-028 ADD rs=1 rt=2 rd=3 accepted at edge 0 -> cycle 1: mem_we=1, mem_addr=0, mem_wdata=0x00221820.
REQ-029 ADDI rs=4 rt=5 imm=0xFFFF, then LOAD rs=0 rt=1 imm=4 with mem_ready=1 -> 0x2085FFFF at addr 0 and 0x80010004 at addr 1, back-to-back, word_count=2.
REQ-030 SUB with mem_ready=0 for 3 cycles -> word and addr stable, in_ready=0, exactly one write on the 4th cycle.
REQ-031 in_op=15 -> illegal=1 for one cycle, mem_we=0, mem_addr unchanged.
REQ-032 ADDR_W=2, 5 NOPs offered -> writes at addr 0-3, full=1 after the 4th, 5th never accepted, word_count=4.
REQ-033 BRANCH_NOP_PAD_EN defined, PAD_COUNT=2, JMP target 0x10 -> 0x08000010 at addr 0, then 0x00000000 at addr 1 and 2, with in_ready=0 until the pad completes.
